cdb_arbiter: RTL and testbench

Common Data Bus arbiter and tag-return engine for the dispatcher. It collects completed results from `NUM_UNITS` execution units, grants one per cycle round-robin, and broadcasts the winner on the CDB. It returns the broadcast tag to the tag free-list through the free-list push port. It also tracks which tags are in flight, so that a retire of an unallocated tag, or a return into a full free list, is flagged rather than corrupting the free list.

---
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant of unit results, registered broadcast,
// and tag return to the free list guarded by an in-flight tag bitmap.
module cdb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS*TAG_W-1:0]  unit_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  output logic [NUM_UNITS-1:0]        unit_ready,
  input  logic                        alloc_valid,
  input  logic [TAG_W-1:0]            alloc_tag,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [TAG_W-1:0]            tag_out,
  output logic                        tag_push,
  input  logic                        fifo_full,
  output logic                        tag_error,
  output logic [15:0]                 bcast_count
);

  // Handshake: a unit holds valid/tag/data stable while unit_valid=1 and
  // unit_ready=0; a cycle with unit_valid=1 and unit_ready=1 consumes the result.

  localparam int PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int NUM_TAGS = 1 << TAG_W;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    win_idx;
  logic                grant;
  logic                legal;
  logic [TAG_W-1:0]    win_tag;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_TAGS-1:0] inflight_q, inflight_d;

  logic                cdb_valid_q;
  logic [TAG_W-1:0]    cdb_tag_q;
  logic [DATA_W-1:0]   cdb_data_q;
  logic                tag_push_q;
  logic                tag_error_q;
  logic [15:0]         count_q;

  // First valid unit at or after rr_ptr, wrapping modulo NUM_UNITS.
  always_comb begin
    grant      = 1'b0;
    win_idx    = '0;
    scan_idx   = '0;
    unit_ready = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + off) % NUM_UNITS);
      if (!grant && unit_valid[scan_idx]) begin
        grant   = 1'b1;
        win_idx = scan_idx;
      end
    end
    if (grant) unit_ready[win_idx] = 1'b1;
  end

  assign win_tag  = unit_tag[int'(win_idx)*TAG_W +: TAG_W];
  assign win_data = unit_data[int'(win_idx)*DATA_W +: DATA_W];
  assign legal    = inflight_q[win_tag] & ~fifo_full;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (int'(win_idx) == NUM_UNITS - 1) ? '0 : win_idx + 1'b1;
    end
  end

  // Alloc is applied after the grant clear so a same-cycle set wins.
  always_comb begin
    inflight_d = inflight_q;
    if (grant)       inflight_d[win_tag]   = 1'b0;
    if (alloc_valid) inflight_d[alloc_tag] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      tag_push_q  <= 1'b0;
      tag_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      cdb_valid_q <= grant;
      tag_push_q  <= grant & legal;
      if (grant) begin
        cdb_tag_q  <= win_tag;
        cdb_data_q <= win_data;
        count_q    <= count_q + 16'd1;
      end
      if (grant && !legal) tag_error_q <= 1'b1;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign tag_out     = cdb_tag_q;
  assign tag_push    = tag_push_q;
  assign tag_error   = tag_error_q;
  assign bcast_count = count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of grants, tag bookkeeping and broadcasts.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int NT = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    unit_valid;
  logic [N*TW-1:0] unit_tag;
  logic [N*DW-1:0] unit_data;
  logic [N-1:0]    unit_ready;
  logic            alloc_valid;
  logic [TW-1:0]   alloc_tag;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [TW-1:0]   tag_out;
  logic            tag_push;
  logic            fifo_full;
  logic            tag_error;
  logic [15:0]     bcast_count;

  cdb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .unit_valid(unit_valid), .unit_tag(unit_tag), .unit_data(unit_data),
    .unit_ready(unit_ready),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .tag_out(tag_out), .tag_push(tag_push), .fifo_full(fifo_full),
    .tag_error(tag_error), .bcast_count(bcast_count)
  );

  // unit driver state
  bit            u_v[N];
  logic [TW-1:0] u_t[N];
  logic [DW-1:0] u_d[N];

  // behavioural model
  int            m_ptr;
  bit            m_inflight[NT];
  logic [15:0]   m_count;
  bit            m_err;
  logic [TW-1:0] m_last_tag;
  logic [DW-1:0] m_last_data;
  int            last_win;

  // scoreboard: {push, tag, data} expected in the cycle after each grant
  logic [DW+TW:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_units();
    for (int i = 0; i < N; i++) begin
      unit_valid[i]           = u_v[i];
      unit_tag[i*TW +: TW]    = u_t[i];
      unit_data[i*DW +: DW]   = u_d[i];
    end
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_count     = '0;
    m_err       = 1'b0;
    m_last_tag  = '0;
    m_last_data = '0;
    last_win    = -1;
    for (int t = 0; t < NT; t++) m_inflight[t] = 1'b0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      u_v[i] = 1'b0; u_t[i] = '0; u_d[i] = '0;
    end
    drive_units();
    alloc_valid = 1'b0;
    alloc_tag   = '0;
    fifo_full   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_tag_out", tag_out, 0);
    chk("rst_tag_push", tag_push, 0);
    chk("rst_tag_error", tag_error, 0);
    chk("rst_bcast_count", bcast_count, 0);
    chk("rst_unit_ready", unit_ready, 0);
  endtask

  // One clock: called shortly after a negedge with inputs already driven.
  // Checks the combinational grant, advances the model, checks the registered outputs.
  task automatic step();
    int            win;
    bit            legal;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    logic [N-1:0]  exp_ready;
    logic [DW+TW:0] e;
    #1;
    win = -1;
    for (int o = 0; o < N; o++) begin
      if (win < 0 && unit_valid[(m_ptr + o) % N]) win = (m_ptr + o) % N;
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("unit_ready", unit_ready, exp_ready);
    if (win >= 0) begin
      t     = unit_tag[win*TW +: TW];
      d     = unit_data[win*DW +: DW];
      legal = m_inflight[t] && !fifo_full;
      exp_q.push_back({legal, t, d});
      m_ptr          = (win + 1) % N;
      m_count        = m_count + 16'd1;
      m_inflight[t]  = 1'b0;
      if (!legal) m_err = 1'b1;
      m_last_tag     = t;
      m_last_data    = d;
    end
    if (alloc_valid) m_inflight[alloc_tag] = 1'b1;
    last_win = win;
    @(posedge clk);
    #1;
    if (win >= 0) begin
      e = exp_q.pop_front();
      chk("cdb_valid", cdb_valid, 1);
      chk("cdb_tag", cdb_tag, e[DW +: TW]);
      chk("cdb_data", cdb_data, e[DW-1:0]);
      chk("tag_push", tag_push, e[DW+TW]);
      chk("tag_out", tag_out, e[DW +: TW]);
      u_v[win] = 1'b0;
    end else begin
      chk("cdb_valid_idle", cdb_valid, 0);
      chk("tag_push_idle", tag_push, 0);
      chk("cdb_tag_hold", cdb_tag, m_last_tag);
      chk("cdb_data_hold", cdb_data, m_last_data);
    end
    chk("bcast_count", bcast_count, m_count);
    chk("tag_error", tag_error, m_err);
    @(negedge clk);
  endtask

  function automatic logic [TW-1:0] pick_tag();
    int s = $urandom_range(0, NT-1);
    for (int o = 0; o < NT; o++) begin
      if (m_inflight[(s + o) % NT]) return TW'((s + o) % NT);
    end
    return TW'($urandom_range(0, NT-1));
  endfunction

  int next_tag;
  int reloads[N];

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // single legal return
    alloc_valid = 1'b1; alloc_tag = 6'd5;
    step();
    alloc_valid = 1'b0;
    u_v[2] = 1'b1; u_t[2] = 6'd5; u_d[2] = 32'hDEADBEEF;
    drive_units();
    step();
    chk("single_tag", cdb_tag, 6'd5);
    chk("single_data", cdb_data, 32'hDEADBEEF);
    chk("single_push", tag_push, 1);
    chk("single_tag_out", tag_out, 6'd5);
    chk("single_count", bcast_count, 16'd1);
    drive_units();
    step();
    // tag 5 is no longer in flight: returning it again must be flagged
    u_v[0] = 1'b1; u_t[0] = 6'd5; u_d[0] = 32'h1;
    drive_units();
    step();
    chk("stale_push", tag_push, 0);
    chk("stale_error", tag_error, 1);

    // round-robin fairness from a fresh pointer
    do_reset();
    for (int t = 10; t < 18; t++) begin
      alloc_valid = 1'b1; alloc_tag = TW'(t);
      step();
    end
    alloc_valid = 1'b0;
    next_tag = 10;
    for (int i = 0; i < N; i++) begin
      u_v[i] = 1'b1; u_t[i] = TW'(next_tag); u_d[i] = $urandom; next_tag++;
      reloads[i] = 0;
    end
    drive_units();
    for (int k = 0; k < 2*N; k++) begin
      step();
      chk("rr_order", last_win, k % N);
      chk("rr_cdb_valid", cdb_valid, 1);
      for (int i = 0; i < N; i++) begin
        if (!u_v[i] && reloads[i] == 0) begin
          u_v[i] = 1'b1; u_t[i] = TW'(next_tag); u_d[i] = $urandom; next_tag++;
          reloads[i] = 1;
        end
      end
      drive_units();
    end
    chk("rr_no_error", tag_error, 0);

    // free list full
    alloc_valid = 1'b1; alloc_tag = 6'd3;
    step();
    alloc_valid = 1'b0;
    u_v[0] = 1'b1; u_t[0] = 6'd3; u_d[0] = 32'hCAFE0003;
    fifo_full = 1'b1;
    drive_units();
    step();
    fifo_full = 1'b0;
    chk("full_valid", cdb_valid, 1);
    chk("full_push", tag_push, 0);
    chk("full_error", tag_error, 1);

    // unallocated tag, error sticky until reset
    do_reset();
    u_v[0] = 1'b1; u_t[0] = 6'd9; u_d[0] = 32'h99;
    drive_units();
    step();
    chk("unalloc_valid", cdb_valid, 1);
    chk("unalloc_tag", cdb_tag, 6'd9);
    chk("unalloc_push", tag_push, 0);
    chk("unalloc_error", tag_error, 1);
    drive_units();
    repeat (3) step();
    chk("unalloc_sticky", tag_error, 1);

    // async reset in the middle of a burst
    do_reset();
    for (int t = 30; t < 34; t++) begin
      alloc_valid = 1'b1; alloc_tag = TW'(t);
      step();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      u_v[i] = 1'b1; u_t[i] = TW'(30 + i); u_d[i] = 32'hB000 + i;
    end
    drive_units();
    step();
    drive_units();
    @(posedge clk);
    #2;
    chk("burst_pre_valid", cdb_valid, 1);
    chk("burst_pre_push", tag_push, 1);
    rst = 1'b1;
    #1;
    chk("burst_rst_valid", cdb_valid, 0);
    chk("burst_rst_push", tag_push, 0);
    chk("burst_rst_count", bcast_count, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    chk("burst_after_push", tag_push, 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!u_v[i] && $urandom_range(0, 99) < 50) begin
          u_v[i] = 1'b1;
          u_t[i] = ($urandom_range(0, 99) < 88) ? pick_tag() : TW'($urandom_range(0, NT-1));
          u_d[i] = $urandom;
        end
      end
      drive_units();
      alloc_valid = ($urandom_range(0, 99) < 40);
      alloc_tag   = TW'($urandom_range(0, NT-1));
      fifo_full   = ($urandom_range(0, 99) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
